// File: rtl/ram_word_ctrl.sv
// Round-robin two-requester word-access controller in front of a byte-wide
// dual-port RAM; each word access runs as four byte accesses, lane 0 first.
module ram_word_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic              m0_we,
  input  logic [ADDR_W-3:0] m0_addr,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_wdata,
  output logic              m0_done,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic              m1_we,
  input  logic [ADDR_W-3:0] m1_addr,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_wdata,
  output logic              m1_done,
  output logic [31:0]       m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WA_W-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;

  logic              accept_c;
  logic              win1_c;
  logic [1:0]        lane_c;

  // Port 1 wins alone, or on a tie when port 0 was not granted last.
  assign win1_c   = m1_req && (!m0_req || !last_q);
  assign accept_c = rst_n && (state_q == S_IDLE) && (m0_req || m1_req);
  // Read byte arriving now belongs to the lane addressed one cycle earlier.
  assign lane_c   = cnt_q - 2'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == 2'd3) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs; strobes are forced low while reset is asserted
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = {addr_q, cnt_q};
    ram_raddr = {addr_q, cnt_q};
    ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    m0_rdata  = rdata_q;
    m1_rdata  = rdata_q;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          m0_gnt = accept_c && !win1_c;
          m1_gnt = accept_c && win1_c;
        end
        S_ACCESS: ram_we = we_q && be_q[cnt_q];
        S_DONE: begin
          m0_done = !owner_q;
          m1_done = owner_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath next values: command latch, lane counter, read assembly
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (accept_c) begin
      owner_d = win1_c;
      last_d  = win1_c;
      cnt_d   = 2'd0;
      we_d    = win1_c ? m1_we    : m0_we;
      addr_d  = win1_c ? m1_addr  : m0_addr;
      be_d    = win1_c ? m1_be    : m0_be;
      wdata_d = win1_c ? m1_wdata : m0_wdata;
    end
    if (state_q == S_ACCESS) cnt_d = cnt_q + 2'd1;
    if (!we_q && (((state_q == S_ACCESS) && (cnt_q != 2'd0)) || (state_q == S_DRAIN)))
      rdata_d[{lane_c, 3'b000} +: 8] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/ram_word_ctrl.md
# ram_word_ctrl

Two-requester word-access controller for the 1024-byte, byte-wide dual-port data RAM (one write port, one read port, one-cycle registered read). It arbitrates round-robin between two 32-bit requesters, such as the core data port and the debug/UART loader. Each accepted word access is sequenced as four byte accesses on the RAM ports. The controller sits directly in front of the RAM; the RAM itself is unchanged.

## Interface
- ADDR_W, 10, RAM byte-address width; word address width is ADDR_W-2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mN_req  in  1  requester N (N=0,1) request valid; held with command until mN_gnt
- mN_gnt  out  1  accept strobe; request taken on the cycle req&&gnt
- mN_we  in  1  1=write, 0=read
- mN_addr  in  ADDR_W-2  word address
- mN_be  in  4  byte enables, bit i = byte lane i (writes only)
- mN_wdata  in  32  write data, lane i = bits [8i+7:8i]
- mN_done  out  1  one-cycle completion pulse to the owning requester
- mN_rdata  out  32  read data, valid while mN_done=1
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write byte address
- ram_raddr  out  ADDR_W  RAM read byte address
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte, valid one cycle after ram_raddr

## Operation
- States: IDLE, ACCESS (lane counter cnt 0..3), DRAIN, DONE.
- IDLE behaviour:
  - mN_gnt=1 only for the arbitration winner whose mN_req=1.
  - On accept, latch we, addr, be, wdata and owner; set cnt=0; go to ACCESS.
- Arbitration:
  - If one port requests, it wins.
  - If both request, the port not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates only on accept.
- ACCESS, each cycle:
  - ram_waddr = ram_raddr = {addr_q, cnt}; lane 0 is at the lowest byte address.
  - ram_wdata = wdata_q lane cnt.
  - ram_we = we_q && be_q[cnt].
  - cnt increments; after cnt=3, go to DRAIN.
- Reads capture ram_rdata into rdata_q lane (cnt-1) on cycles cnt=1..3, and lane 3 in DRAIN.
- Writes ignore ram_rdata. Reads ignore be, and all four lanes are read.
- DRAIN goes to DONE. DONE pulses mN_done for the owner only, then goes to IDLE.
- mN_rdata is driven from rdata_q on both ports. For writes it holds the previous read value (don't-care).
- be=0 write: no ram_we pulse, but full sequencing and a done pulse still occur.
- Outside ACCESS: ram_we=0 and addresses hold {addr_q, cnt}.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; cnt, addr_q, we_q, be_q, wdata_q and rdata_q clear to 0; last_grant becomes 1.
  - All gnt/done/ram_we outputs are 0 and addresses are 0.
  - An in-flight access is abandoned with no done pulse. Bytes already written stay in RAM.

## Timing
- Accept at cycle T (req&&gnt). ACCESS cnt=0..3 occupies T+1..T+4, DRAIN is T+5, done pulse at T+6, back in IDLE at T+7.
- Fixed latency of 6 cycles from accept to done, reads and writes alike.
- Next accept no earlier than T+7; peak throughput is 1 word per 7 cycles.
- Read lane k address is driven in T+1+k. Data appears on ram_rdata in T+2+k and is captured at the end of that cycle.
- mN_gnt is combinational from state, last_grant and req. It is 0 in every non-IDLE state and during reset.
- A losing requester keeps req high and is granted at the next IDLE, so no starvation with two ports.

## Test plan
- Reset, then port 0 writes addr=0x05, be=4'b1111, wdata=0xDDCCBBAA.
  - ram_we=1 in T+1..T+4 at bytes 0x014..0x017 with data AA, BB, CC, DD.
  - m0_done=1 at T+6 only.
- Port 1 reads addr=0x05 after the above write: ram_raddr 0x014..0x017 in T+1..T+4; m1_done at T+6 with m1_rdata=0xDDCCBBAA; m0_done stays 0.
- Partial write: port 0 writes addr=0x05, be=4'b0101, wdata=0x11223344, then reads it back. ram_we only at 0x014 and 0x016; readback = 0xDD22BB44.
- Both ports raise req in the same cycle after reset and keep requesting. Grants alternate 0,1,0,1 with accepts 7 cycles apart; each done goes only to its owner.
- Assert rst_n=0 at T+3 of a write to addr=0x10 with be=4'b1111.
  - Next cycle: IDLE, all outputs 0, no done pulse.
  - Bytes 0x040..0x041 are written, 0x042..0x043 unchanged.
  - Port 0 wins the next tie.
- Write with be=0 to addr=0xFF: no ram_we pulse, done at T+6. A following read of 0xFF returns the prior contents of 0x3FC..0x3FF (top-of-RAM wrap check, addresses never exceed 0x3FF).
